// File: rtl/decode_pkg.sv
// Opcode/ALU-op encodings, the decoded control bundle and the pure decode
// function shared by the decode stage. The bundle is sized for the widest
// supported configuration; the stage keeps only the bits it needs.
package decode_pkg;

    localparam int MAX_W     = 32;
    localparam int MAX_REG_W = 8;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDI = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBI = 5'd3;
    localparam logic [4:0] OP_MOV  = 5'd4;
    localparam logic [4:0] OP_MOVI = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHLI = 5'd7;
    localparam logic [4:0] OP_ASR  = 5'd8;
    localparam logic [4:0] OP_ASRI = 5'd9;
    localparam logic [4:0] OP_LSR  = 5'd10;
    localparam logic [4:0] OP_LSRI = 5'd11;
    localparam logic [4:0] OP_ROL  = 5'd12;
    localparam logic [4:0] OP_ROLI = 5'd13;
    localparam logic [4:0] OP_ROR  = 5'd14;
    localparam logic [4:0] OP_RORI = 5'd15;
    localparam logic [4:0] OP_AND  = 5'd16;
    localparam logic [4:0] OP_ANDI = 5'd17;
    localparam logic [4:0] OP_OR   = 5'd18;
    localparam logic [4:0] OP_ORI  = 5'd19;
    localparam logic [4:0] OP_NOT  = 5'd20;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SHL = 4'd2;
    localparam logic [3:0] ALU_ASR = 4'd3;
    localparam logic [3:0] ALU_LSR = 4'd4;
    localparam logic [3:0] ALU_ROL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_AND = 4'd8;
    localparam logic [3:0] ALU_OR  = 4'd9;
    localparam logic [3:0] ALU_NOT = 4'd10;

    typedef struct packed {
        logic                 unary;
        logic                 sgned;
        logic                 imode;
        logic [3:0]           aluop;
        logic                 setcc;
        logic                 illegal;
        logic                 wben;
        logic [MAX_REG_W-1:0] rd;
        logic [MAX_REG_W-1:0] ra;
        logic [MAX_REG_W-1:0] rb;
        logic [MAX_W-1:0]     imm;
    } dec_t;

    // Decode one instruction word; unused fields come back as zero and an
    // illegal opcode (or a field layout that does not fit) yields only illegal=1.
    function automatic dec_t decode_instr(
        input logic [MAX_W-1:0] instr,
        input int               instr_w,
        input int               reg_w,
        input int               imm_w
    );
        dec_t             d;
        logic [4:0]       op;
        logic [MAX_W-1:0] reg_mask;
        logic [MAX_W-1:0] imm_mask;
        logic [MAX_W-1:0] sign_bit;
        logic [MAX_W-1:0] imm_raw;
        logic [MAX_W-1:0] rd_f;
        logic [MAX_W-1:0] ra_f;
        logic [MAX_W-1:0] rb_f;

        d        = '0;
        op       = instr[4:0];
        reg_mask = ~({MAX_W{1'b1}} << reg_w);
        imm_mask = ~({MAX_W{1'b1}} << imm_w);
        sign_bit = {{(MAX_W-1){1'b0}}, 1'b1} << (imm_w - 1);
        rd_f     = (instr >> 6) & reg_mask;
        ra_f     = (instr >> (6 + reg_w)) & reg_mask;
        rb_f     = (instr >> (6 + 2 * reg_w)) & reg_mask;
        imm_raw  = (instr >> (instr_w - imm_w)) & imm_mask;

        if ((op <= OP_NOT) && ((6 + 3 * reg_w) <= instr_w)) begin
            d.unary = (op == OP_MOV) || (op == OP_MOVI) || (op == OP_NOT);
            d.sgned = (op <= OP_MOVI);
            d.imode = op[0];
            d.setcc = instr[5];
            d.wben  = 1'b1;
            case (op)
                OP_ADD, OP_ADDI: d.aluop = ALU_ADD;
                OP_SUB, OP_SUBI: d.aluop = ALU_SUB;
                OP_MOV, OP_MOVI: d.aluop = ALU_ADD;
                OP_SHL, OP_SHLI: d.aluop = ALU_SHL;
                OP_ASR, OP_ASRI: d.aluop = ALU_ASR;
                OP_LSR, OP_LSRI: d.aluop = ALU_LSR;
                OP_ROL, OP_ROLI: d.aluop = ALU_ROL;
                OP_ROR, OP_RORI: d.aluop = ALU_ROR;
                OP_AND, OP_ANDI: d.aluop = ALU_AND;
                OP_OR,  OP_ORI:  d.aluop = ALU_OR;
                OP_NOT:          d.aluop = ALU_NOT;
                default:         d.aluop = ALU_ADD;
            endcase
            d.rd = rd_f[MAX_REG_W-1:0];
            if (!d.unary) begin
                d.ra = ra_f[MAX_REG_W-1:0];
            end
            // MOVI is both unary and imode, so it never reads rB either.
            if (!d.imode) begin
                d.rb = rb_f[MAX_REG_W-1:0];
            end else if (d.sgned && (|(imm_raw & sign_bit))) begin
                d.imm = imm_raw | ~imm_mask;
            end else begin
                d.imm = imm_raw;
            end
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared on writeback (set wins on collision), plus the hazard check for
// the instruction currently held in the decode stage.
module decode_scoreboard #(
    parameter int REG_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_en,
    input  logic [REG_W-1:0]   set_idx,
    input  logic               clr_en,
    input  logic [REG_W-1:0]   clr_idx,
    input  logic               chk_legal,
    input  logic               chk_ra_use,
    input  logic [REG_W-1:0]   chk_ra,
    input  logic               chk_rb_use,
    input  logic [REG_W-1:0]   chk_rb,
    input  logic               chk_wben,
    input  logic [REG_W-1:0]   chk_rd,
    output logic [2**REG_W-1:0] busy,
    output logic               hazard
);

    logic [2**REG_W-1:0] busy_q;
    logic [2**REG_W-1:0] busy_nxt;

    // Apply the writeback clear first so a same-cycle issue to that register wins.
    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_idx] = 1'b1;
        end
    end

    // Busy-bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // Hazards look only at registered busy bits; writeback is not bypassed.
    assign hazard = chk_legal &
                    ((chk_ra_use & busy_q[chk_ra]) |
                     (chk_rb_use & busy_q[chk_rb]) |
                     (chk_wben   & busy_q[chk_rd]));

    assign busy = busy_q;

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: decodes on acceptance from fetch,
// holds the bundle until it is free of register hazards and execute takes it.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_W   = 3,
    parameter int IMM_W   = 4,
    parameter int DATA_W  = 16,
    localparam int NREGS  = 2**REG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_unary,
    output logic               out_sgned,
    output logic               out_imode,
    output logic               out_setcc,
    output logic               out_wben,
    output logic               out_illegal,
    output logic [3:0]         out_aluop,
    output logic [REG_W-1:0]   out_rd,
    output logic [REG_W-1:0]   out_ra,
    output logic [REG_W-1:0]   out_rb,
    output logic [DATA_W-1:0]  out_imm,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_rd,
    output logic [NREGS-1:0]   sb_busy
);

    logic [MAX_W-1:0] instr_ext;
    dec_t             dec_p0;
    dec_t             bundle_p1;
    logic             vld_p1;
    logic             accept;
    logic             issue;
    logic             hazard;
    logic             unused_bundle;

    // Stage 0: combinational decode of the incoming word
    assign instr_ext = MAX_W'(in_instr);
    assign dec_p0    = decode_instr(instr_ext, INSTR_W, REG_W, IMM_W);

    assign accept   = in_valid & in_ready;
    assign issue    = out_valid & out_ready;
    assign in_ready = ~vld_p1 | issue | flush;

    // Held flag: flush wins, then a new acceptance, then a completed issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (issue) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage 1: decoded bundle, loaded only on an unflushed acceptance so it
    // stays stable while execute stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_p1 <= '0;
        end else if (accept && !flush) begin
            bundle_p1 <= dec_p0;
        end
    end

    decode_scoreboard #(
        .REG_W (REG_W)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (issue & bundle_p1.wben),
        .set_idx    (out_rd),
        .clr_en     (wb_valid),
        .clr_idx    (wb_rd),
        .chk_legal  (~bundle_p1.illegal),
        .chk_ra_use (~bundle_p1.unary),
        .chk_ra     (out_ra),
        .chk_rb_use (~bundle_p1.imode),
        .chk_rb     (out_rb),
        .chk_wben   (bundle_p1.wben),
        .chk_rd     (out_rd),
        .busy       (sb_busy),
        .hazard     (hazard)
    );

    assign out_valid   = vld_p1 & ~hazard;
    assign out_unary   = bundle_p1.unary;
    assign out_sgned   = bundle_p1.sgned;
    assign out_imode   = bundle_p1.imode;
    assign out_setcc   = bundle_p1.setcc;
    assign out_wben    = bundle_p1.wben;
    assign out_illegal = bundle_p1.illegal;
    assign out_aluop   = bundle_p1.aluop;
    assign out_rd      = bundle_p1.rd[REG_W-1:0];
    assign out_ra      = bundle_p1.ra[REG_W-1:0];
    assign out_rb      = bundle_p1.rb[REG_W-1:0];
    assign out_imm     = bundle_p1.imm[DATA_W-1:0];

    // The generic-width bundle carries bits beyond this configuration.
    assign unused_bundle = ^bundle_p1;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    typedef struct packed {
        logic        unary;
        logic        sgned;
        logic        imode;
        logic        setcc;
        logic        wben;
        logic        illegal;
        logic [3:0]  aluop;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic        out_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_rd = 3'd0;
    logic        in_ready, out_valid;
    logic        out_unary, out_sgned, out_imode, out_setcc, out_wben, out_illegal;
    logic [3:0]  out_aluop;
    logic [2:0]  out_rd, out_ra, out_rb;
    logic [15:0] out_imm;
    logic [7:0]  sb_busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t act;
    exp_t popped;
    exp_t dropped;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_unary(out_unary), .out_sgned(out_sgned), .out_imode(out_imode),
        .out_setcc(out_setcc), .out_wben(out_wben), .out_illegal(out_illegal),
        .out_aluop(out_aluop), .out_rd(out_rd), .out_ra(out_ra), .out_rb(out_rb),
        .out_imm(out_imm), .wb_valid(wb_valid), .wb_rd(wb_rd), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    assign act = {out_unary, out_sgned, out_imode, out_setcc, out_wben, out_illegal,
                  out_aluop, out_rd, out_ra, out_rb, out_imm};

    function automatic exp_t mk(input logic u, input logic s, input logic im,
                                input logic sc, input logic wb, input logic il,
                                input logic [3:0] op, input logic [2:0] rd,
                                input logic [2:0] ra, input logic [2:0] rb,
                                input logic [15:0] imm);
        return {u, s, im, sc, wb, il, op, rd, ra, rb, imm};
    endfunction

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    // Offer one instruction; push its expectation at the accepting edge.
    task automatic send(input logic [15:0] instr, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for %h", instr);
        end else if (!flush) begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic retire(input logic [2:0] r);
        wb_valid = 1'b1;
        wb_rd = r;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    // Output monitor: every presented bundle must equal the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %h expected nothing", act);
            end else begin
                if (act !== exp_q[0]) begin
                    errors++;
                    $display("FAIL out_fields: got %h expected %h", act, exp_q[0]);
                end
                if (out_ready) popped = exp_q.pop_front();
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t eadd, eaddi, eandi, eill, esub;
        logic [15:0] s_instr [8];
        exp_t        s_exp [8];
        bit          done;
        int          n;

        eadd  = mk(0,1,0,0,1,0, 4'd0, 3'd1,3'd2,3'd3, 16'h0000);
        eaddi = mk(0,1,1,0,1,0, 4'd0, 3'd1,3'd2,3'd0, 16'hFFFF);
        eandi = mk(0,0,1,0,1,0, 4'd8, 3'd1,3'd2,3'd0, 16'h000F);
        eill  = mk(0,0,0,0,0,1, 4'd0, 3'd0,3'd0,3'd0, 16'h0000);
        esub  = mk(0,1,0,0,1,0, 4'd1, 3'd4,3'd1,3'd0, 16'h0000);

        s_instr[0] = 16'h7E05; s_exp[0] = mk(1,1,1,0,1,0, 4'd0, 3'd0,3'd0,3'd0, 16'h0007);
        s_instr[1] = 16'h8E85; s_exp[1] = mk(1,1,1,0,1,0, 4'd0, 3'd2,3'd0,3'd0, 16'hFFF8);
        s_instr[2] = 16'h0015; s_exp[2] = eill;
        s_instr[3] = 16'hFEC5; s_exp[3] = mk(1,1,1,0,1,0, 4'd0, 3'd3,3'd0,3'd0, 16'hFFFF);
        s_instr[4] = 16'h5F45; s_exp[4] = mk(1,1,1,0,1,0, 4'd0, 3'd5,3'd0,3'd0, 16'h0005);
        s_instr[5] = 16'hFFFF; s_exp[5] = eill;
        s_instr[6] = 16'h0F85; s_exp[6] = mk(1,1,1,0,1,0, 4'd0, 3'd6,3'd0,3'd0, 16'h0000);
        s_instr[7] = 16'h3FE5; s_exp[7] = mk(1,1,1,1,1,0, 4'd0, 3'd7,3'd0,3'd0, 16'h0003);

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(sb_busy), 64'd0);
        chk("rst_fields", 64'(act), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD r1,r2,r3: one-cycle latency, then r1 pending
        out_ready = 1'b1;
        send(16'h3440, eadd);
        @(negedge clk);
        chk("latency", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("busy_add", 64'(sb_busy), 64'h02);

        // SUB r4,r1,r0 stalls on r1 until writeback, released the cycle after
        send(16'h0302, esub);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd0);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b1;
        wb_rd = 3'd1;
        @(negedge clk);
        chk("wb_no_bypass", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        @(negedge clk);
        chk("release", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("busy_sub", 64'(sb_busy), 64'h10);
        retire(3'd4);
        chk("busy_clear", 64'(sb_busy), 64'h00);

        // ADDI r1 issued in the same cycle as writeback of r1: set wins
        send(16'hF441, eaddi);
        wb_valid = 1'b1;
        wb_rd = 3'd1;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        chk("set_wins", 64'(sb_busy), 64'h02);
        retire(3'd1);

        // ANDI: zero-extended immediate
        send(16'hF451, eandi);
        @(posedge clk);
        #1;
        chk("busy_andi", 64'(sb_busy), 64'h02);
        retire(3'd1);

        // Illegal opcode passes through with no scoreboard effect
        send(16'h0015, eill);
        @(posedge clk);
        #1;
        chk("illegal_busy", 64'(sb_busy), 64'h00);

        // Flush a held instruction; the input offered during flush is discarded
        out_ready = 1'b0;
        send(16'h3440, eadd);
        @(negedge clk);
        chk("held_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'h0302;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        dropped = exp_q.pop_back();
        @(negedge clk);
        chk("flush_drop", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(sb_busy), 64'h00);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'hF451, eandi);
        @(posedge clk);
        #1;
        retire(3'd1);

        // Stream of 8 independent instructions with out_ready toggling
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) send(s_instr[k], s_exp[k]);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("stream_drain", 64'(exp_q.size()), 64'd0);
        chk("stream_busy", 64'(sb_busy), 64'hED);
        for (int r = 0; r < 8; r++) retire(3'(r));
        chk("final_busy", 64'(sb_busy), 64'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
